instr_sequencer: RTL and testbench
==================================

Name: instr_sequencer

Overview:
- Fetch/issue front end of the HRM CPU: reads program bytes, holds the instruction register and drives the 4-bit opcode `instr` into the control unit.
- Consumes the control unit's `branch`, `ijump`, `rIn` and `wO` outputs. Uses them to resolve the next PC and to handshake with the inbox and outbox FIFOs.
- Produces `exec_en`, which gates the datapath write strobes (wR, wM) so that state is written only in the commit cycle.

Parameters:
- PC_W, 8, program counter / program memory address width.
- HAS_ARG, 16'hFF3C, bit k set: opcode k is followed by a one-byte operand.
- HALT_OP, 4'hF, opcode that halts the sequencer.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- pm_addr  out  PC_W  program memory address; synchronous ROM, data valid one cycle later
- pm_data  in  8  program memory read data
- instr  out  4  opcode to control unit; equals IR[7:4]
- operand  out  8  operand byte to datapath (memory address or jump target)
- branch  in  1  conditional-jump request from control unit
- ijump  in  1  unconditional-jump request from control unit
- rIn  in  1  instruction reads inbox
- wO  in  1  instruction writes outbox
- r_zero  in  1  R register == 0
- r_neg  in  1  R register MSB
- inbox_empty  in  1  inbox FIFO empty
- inbox_rd  out  1  one-cycle pop strobe
- outbox_full  in  1  outbox FIFO full
- outbox_wr  out  1  one-cycle push strobe
- exec_en  out  1  commit cycle; datapath writes only when 1
- halted  out  1  sequencer stopped
- pc  out  PC_W  current program counter (debug)

Behaviour:
- Reset (async, rst_n=0):
  - PC=0, IR=0, operand=0, state=F_OP.
  - inbox_rd, outbox_wr, exec_en and halted are all 0.
- Instruction flow: F_OP → L_OP → [F_ARG → L_ARG] → EXEC.
  - F_OP: pm_addr=PC.
  - L_OP: IR←pm_data, PC←PC+1.
  - If HAS_ARG[pm_data[7:4]] is set, go to F_ARG; else go to EXEC.
  - F_ARG: pm_addr=PC.
  - L_ARG: operand←pm_data, PC←PC+1, go to EXEC.
- EXEC (single cycle, decisions from combinational control-unit outputs):
  - instr==HALT_OP: go to HALT, halted=1, no strobes.
  - rIn and inbox_empty: go to HALT with exec_en=0. An empty inbox ends the program.
  - wO and outbox_full: go to WAIT_O with exec_en=0.
  - Otherwise: exec_en=1, inbox_rd=rIn, outbox_wr=wO.
    - take = ijump | (branch & (instr[0] ? r_neg : r_zero)).
    - PC←take ? operand[PC_W-1:0] : PC. The PC was already incremented during fetch.
    - Go to F_OP.
- WAIT_O: hold IR and operand, all strobes 0.
  - When outbox_full drops, perform the EXEC commit (exec_en=1, outbox_wr=1) in that same cycle, then go to F_OP.
- HALT: terminal state; only reset exits it. instr holds its last value, exec_en=0.
- Latency: 3 cycles for a no-operand instruction, 5 cycles with an operand; plus the cycles spent in WAIT_O.
- PC wraps from 2^PC_W-1 to 0 with no error.
- Every strobe is active for exactly one cycle per committed instruction. A strobe is never asserted outside EXEC or WAIT_O.
- Reset mid-instruction aborts it: no strobe, no PC change beyond the reset value.
- Branch conditions are sampled only in the commit cycle.

Optional Feature:
- Macro: INSTR_SEQUENCER_STEP_EN.
- When defined, two extra ports are added:
  - step (in, 1): one-cycle pulse.
  - run (in, 1): level.
  - With run=0, the sequencer waits in F_OP until a step pulse, so it executes one instruction per pulse.
  - With run=1, it behaves as if the feature were absent.
- When undefined: no step or run ports; free-running.

Decomposition:
- Shared package hrm_pkg holds:
  - the opcode constants (OP_INBOX, OP_OUTBOX, OP_COPYFROM, OP_COPYTO, OP_ADD, OP_SUB, OP_BUMPP, OP_BUMPN, OP_JUMP, OP_JUMPZ, OP_JUMPN, OP_HALT);
  - the HAS_ARG default mask;
  - the sequencer state enum.
- No sub-module. The control unit stays external, and the sequencer only consumes its decoded signals.

Test Plan:
- Reset mid-L_ARG, release → pm_addr=0 next cycle, no strobes, pc=0.
- Program {INBOX, OUTBOX}, inbox 2 items, outbox not full → two inbox_rd and two outbox_wr pulses, each 3 cycles apart. Third INBOX on empty inbox → halted=1, inbox_rd stays 0.
- JUMPZ 0x10 with r_zero=1 → pc=0x10 after commit. Same with r_zero=0 → pc=PC+2.
- OUTBOX with outbox_full held 4 cycles → exec_en=0 for 4 cycles, then a single outbox_wr pulse with exec_en=1.
- JUMP at 0xFE with operand byte at 0xFF → PC wraps to 0 during fetch, then loads operand. Unconditional jump taken regardless of flags.
- With INSTR_SEQUENCER_STEP_EN, run=0 → no fetch progress. One step pulse → exactly one exec_en pulse.

Source files
------------

// File: rtl/hrm_pkg.sv
// -----------------------------------------------------------------------------
// hrm_pkg -- shared definitions for the HRM CPU front end.
//   * Opcode constants, as they appear in IR[7:4].
//   * HAS_ARG_DEFAULT: bit k set means opcode k is followed by an operand byte.
//   * seq_state_e: the instruction sequencer state encoding.
//   * op_has_arg(): looks up the operand-present bit for an opcode.
// Conditional jumps are laid out so that opcode bit 0 picks the flag.
// Bit 0 clear (JUMPZ) tests r_zero. Bit 0 set (JUMPN) tests r_neg.
// -----------------------------------------------------------------------------
package hrm_pkg;

    localparam logic [3:0] OP_INBOX    = 4'h0;
    localparam logic [3:0] OP_OUTBOX   = 4'h1;
    localparam logic [3:0] OP_COPYFROM = 4'h2;
    localparam logic [3:0] OP_COPYTO   = 4'h3;
    localparam logic [3:0] OP_ADD      = 4'h4;
    localparam logic [3:0] OP_SUB      = 4'h5;
    localparam logic [3:0] OP_BUMPP    = 4'h6;
    localparam logic [3:0] OP_BUMPN    = 4'h7;
    localparam logic [3:0] OP_JUMP     = 4'h8;
    localparam logic [3:0] OP_JUMPZ    = 4'hA;
    localparam logic [3:0] OP_JUMPN    = 4'hB;
    localparam logic [3:0] OP_HALT     = 4'hF;

    localparam logic [15:0] HAS_ARG_DEFAULT = 16'hFF3C;

    typedef enum logic [2:0] {
        F_OP   = 3'd0,
        L_OP   = 3'd1,
        F_ARG  = 3'd2,
        L_ARG  = 3'd3,
        EXEC   = 3'd4,
        WAIT_O = 3'd5,
        HALT   = 3'd6
    } seq_state_e;

    function automatic logic op_has_arg(input logic [15:0] mask, input logic [3:0] op);
        op_has_arg = mask[op];
    endfunction

endpackage

// File: rtl/instr_sequencer.sv
// -----------------------------------------------------------------------------
// instr_sequencer -- fetch/issue front end of the HRM CPU.
//
// This block fetches the opcode byte and, when the opcode needs one, the
// operand byte from a synchronous program ROM. It then presents the opcode to
// the external control unit. In the commit cycle it resolves the next PC and
// raises the inbox/outbox strobes.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   pm_addr / pm_data  program ROM address (data returns one cycle later)
//   instr, operand     current opcode (IR[7:4]) and operand byte
//   branch, ijump      conditional / unconditional jump request (control unit)
//   rIn, wO            instruction pops the inbox / pushes the outbox
//   r_zero, r_neg      R register flags used by conditional jumps
//   inbox_empty        inbox FIFO empty; an INBOX on an empty inbox halts
//   inbox_rd           one-cycle inbox pop strobe
//   outbox_full        outbox FIFO full; an OUTBOX stalls in WAIT_O
//   outbox_wr          one-cycle outbox push strobe
//   exec_en            commit cycle; the datapath writes only when it is high
//   halted             sequencer stopped (only reset leaves this state)
//   pc                 current program counter (debug)
//
// Optional build macro INSTR_SEQUENCER_STEP_EN adds two inputs:
//   step  one-cycle pulse
//   run   level
// With run=0, the sequencer waits in F_OP until it sees a step pulse.
//
// The strobes and exec_en are decoded from the registered state together
// with the control unit's combinational outputs. The control unit's outputs
// are themselves a function of the registered opcode, so this decode is
// necessary: the commit decision has to land in the same cycle.
// -----------------------------------------------------------------------------
module instr_sequencer
    import hrm_pkg::*;
#(
    parameter int          PC_W    = 8,
    parameter logic [15:0] HAS_ARG = HAS_ARG_DEFAULT,
    parameter logic [3:0]  HALT_OP = OP_HALT
) (
    input  logic            clk,
    input  logic            rst_n,
`ifdef INSTR_SEQUENCER_STEP_EN
    input  logic            step,
    input  logic            run,
`endif
    output logic [PC_W-1:0] pm_addr,
    input  logic [7:0]      pm_data,
    output logic [3:0]      instr,
    output logic [7:0]      operand,
    input  logic            branch,
    input  logic            ijump,
    input  logic            rIn,
    input  logic            wO,
    input  logic            r_zero,
    input  logic            r_neg,
    input  logic            inbox_empty,
    output logic            inbox_rd,
    input  logic            outbox_full,
    output logic            outbox_wr,
    output logic            exec_en,
    output logic            halted,
    output logic [PC_W-1:0] pc
);

    localparam logic [PC_W-1:0] PC_ZERO = {PC_W{1'b0}};
    localparam logic [PC_W-1:0] PC_ONE  = {{(PC_W-1){1'b0}}, 1'b1};

    seq_state_e      state_r, state_d;
    logic [PC_W-1:0] pc_r, pc_d;
    // The sequencer uses only the opcode nibble of IR, so only that nibble
    // is kept.
    logic [3:0]      ir_r, ir_d;
    logic [7:0]      operand_r, operand_d;
    logic            halted_r, halted_d;

    logic            go_s;
    logic            take_s;
    logic            commit_s;
    logic [PC_W-1:0] target_s;
    logic            exec_en_s, inbox_rd_s, outbox_wr_s;

`ifdef INSTR_SEQUENCER_STEP_EN
    assign go_s = run | step;
`else
    assign go_s = 1'b1;
`endif

    // Opcode bit 0 chooses which flag a conditional jump tests.
    assign take_s   = ijump | (branch & (ir_r[0] ? r_neg : r_zero));
    assign target_s = PC_W'(operand_r);

    // Next-state, datapath-register and strobe decode.
    always_comb begin
        state_d     = state_r;
        pc_d        = pc_r;
        ir_d        = ir_r;
        operand_d   = operand_r;
        halted_d    = halted_r;
        commit_s    = 1'b0;
        exec_en_s   = 1'b0;
        inbox_rd_s  = 1'b0;
        outbox_wr_s = 1'b0;

        case (state_r)
            F_OP: begin
                if (go_s) begin
                    state_d = L_OP;
                end else begin
                    state_d = F_OP;
                end
            end
            L_OP: begin
                ir_d = pm_data[7:4];
                pc_d = pc_r + PC_ONE;
                if (op_has_arg(HAS_ARG, pm_data[7:4])) begin
                    state_d = F_ARG;
                end else begin
                    state_d = EXEC;
                end
            end
            F_ARG: begin
                state_d = L_ARG;
            end
            L_ARG: begin
                operand_d = pm_data;
                pc_d      = pc_r + PC_ONE;
                state_d   = EXEC;
            end
            EXEC: begin
                if (ir_r == HALT_OP) begin
                    state_d  = HALT;
                    halted_d = 1'b1;
                end else if (rIn && inbox_empty) begin
                    // Running out of input is the normal end of a program.
                    state_d  = HALT;
                    halted_d = 1'b1;
                end else if (wO && outbox_full) begin
                    state_d = WAIT_O;
                end else begin
                    commit_s = 1'b1;
                end
            end
            WAIT_O: begin
                if (!outbox_full) begin
                    commit_s = 1'b1;
                end else begin
                    state_d = WAIT_O;
                end
            end
            HALT: begin
                state_d  = HALT;
                halted_d = 1'b1;
            end
            default: begin
                state_d = F_OP;
            end
        endcase

        // The PC already points past the fetched bytes, so a jump that is not
        // taken leaves it unchanged.
        if (commit_s) begin
            exec_en_s   = 1'b1;
            inbox_rd_s  = rIn;
            outbox_wr_s = wO;
            state_d     = F_OP;
            if (take_s) begin
                pc_d = target_s;
            end else begin
                pc_d = pc_d;
            end
        end else begin
            exec_en_s = 1'b0;
        end
    end

    // State, PC, IR, operand and halted registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= F_OP;
            pc_r      <= PC_ZERO;
            ir_r      <= 4'h0;
            operand_r <= 8'h00;
            halted_r  <= 1'b0;
        end else begin
            state_r   <= state_d;
            pc_r      <= pc_d;
            ir_r      <= ir_d;
            operand_r <= operand_d;
            halted_r  <= halted_d;
        end
    end

    assign pm_addr   = pc_r;
    assign pc        = pc_r;
    assign instr     = ir_r;
    assign operand   = operand_r;
    assign halted    = halted_r;
    assign exec_en   = exec_en_s;
    assign inbox_rd  = inbox_rd_s;
    assign outbox_wr = outbox_wr_s;

endmodule

// File: tb/tb_instr_sequencer.sv
// -----------------------------------------------------------------------------
// tb_instr_sequencer -- self-checking bench for instr_sequencer.
//
// The bench emulates the following around the DUT:
//   * a synchronous ROM (rom[]);
//   * a minimal control unit that decodes instr;
//   * inbox and outbox FIFO status.
//
// run_instr() predicts the outcome of each instruction at instruction level:
//   * fetch length from the operand mask;
//   * commit latency of 3 or 5 cycles, plus the cycles the outbox is full;
//   * the jump rule;
//   * halting.
// It then checks the DUT cycle by cycle. Build with INSTR_SEQUENCER_STEP_EN
// defined to also exercise the step/run ports.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_instr_sequencer;
    import hrm_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] pm_addr;
    logic [7:0] pm_data = 8'h00;
    logic [3:0] instr;
    logic [7:0] operand;
    logic       branch, ijump, rIn, wO;
    logic       r_zero = 1'b0, r_neg = 1'b0;
    logic       inbox_empty = 1'b0, outbox_full = 1'b0;
    logic       inbox_rd, outbox_wr, exec_en, halted;
    logic [7:0] pc;
`ifdef INSTR_SEQUENCER_STEP_EN
    logic       step = 1'b0;
    logic       run = 1'b1;
`endif

    logic [7:0] rom [256];
    logic [7:0] pc_m;
    int         inbox_cnt;
    int         errors = 0;
    int         checks = 0;

    always #5 clk = ~clk;

    // Synchronous program ROM: data appears one cycle after the address.
    always @(posedge clk) pm_data <= rom[pm_addr];

    // Minimal control unit.
    assign rIn    = (instr == OP_INBOX);
    assign wO     = (instr == OP_OUTBOX);
    assign ijump  = (instr == OP_JUMP);
    assign branch = (instr == OP_JUMPZ) || (instr == OP_JUMPN);

    instr_sequencer dut (
        .clk(clk), .rst_n(rst_n),
`ifdef INSTR_SEQUENCER_STEP_EN
        .step(step), .run(run),
`endif
        .pm_addr(pm_addr), .pm_data(pm_data), .instr(instr), .operand(operand),
        .branch(branch), .ijump(ijump), .rIn(rIn), .wO(wO),
        .r_zero(r_zero), .r_neg(r_neg),
        .inbox_empty(inbox_empty), .inbox_rd(inbox_rd),
        .outbox_full(outbox_full), .outbox_wr(outbox_wr),
        .exec_en(exec_en), .halted(halted), .pc(pc)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic has_arg(input logic [3:0] op);
        logic [15:0] m;
        m = 16'hFF3C;
        return m[op];
    endfunction

    task automatic clear_rom();
        for (int a = 0; a < 256; a++) rom[a] = 8'h60;
    endtask

    // Apply reset and release it on a falling edge.
    // Returns at negedge+1 of the first F_OP cycle.
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        outbox_full = 1'b0;
        inbox_empty = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        pc_m = 8'h00;
    endtask

    // Execute one instruction starting at negedge+1 of its F_OP cycle.
    // full_n is the number of cycles the outbox stays full.
    // fz / fn are forced r_zero / r_neg values in the EXEC/WAIT cycles;
    // -1 means random.
    task automatic run_instr(input int full_n, input int fz, input int fn, input string tag);
        logic [7:0] pc0, ob, arg, seq_pc, exp_pc;
        logic [3:0] op;
        logic       has, z_at, n_at, ird_at, owr_at, take;
        logic [3:0] instr_at;
        logic [7:0] opnd_at;
        bit         exp_halt;
        int         lat, exp_c, c, stray;
        pc0    = pc_m;
        ob     = rom[pc0];
        op     = ob[7:4];
        has    = has_arg(op);
        arg    = rom[8'(pc0 + 8'd1)];
        lat    = has ? 5 : 3;
        seq_pc = pc0 + (has ? 8'd2 : 8'd1);
        exp_halt = (op == OP_HALT) || (op == OP_INBOX && inbox_cnt == 0);
        exp_c  = lat - 1 + full_n;
        c = -1; stray = 0;
        z_at = 1'b0; n_at = 1'b0; ird_at = 1'b0; owr_at = 1'b0;
        instr_at = 4'h0; opnd_at = 8'h00;
        for (int i = 0; i <= exp_c + 2 && c < 0; i++) begin
            if (i > 0) @(negedge clk);
            outbox_full = (full_n > 0) && (i < lat - 1 + full_n);
            inbox_empty = (inbox_cnt == 0);
            r_zero = (fz < 0 || i < lat - 1) ? 1'($urandom_range(0, 1)) : fz[0];
            r_neg  = (fn < 0 || i < lat - 1) ? 1'($urandom_range(0, 1)) : fn[0];
            #1;
            if (i == 0) begin
                checks++;
                if (pm_addr !== pc0 || pc !== pc0 || halted !== 1'b0) begin
                    errors++;
                    $display("FAIL %s fetch_addr: pm_addr=%h pc=%h halted=%b, want %h/%h/0", tag, pm_addr, pc, halted, pc0, pc0);
                end
            end
            if (i == lat - 1) begin
                checks++;
                if (pc !== seq_pc) begin
                    errors++;
                    $display("FAIL %s pc_after_fetch: got %h want %h", tag, pc, seq_pc);
                end
            end
            if (exec_en === 1'b1) begin
                c = i; z_at = r_zero; n_at = r_neg;
                ird_at = inbox_rd; owr_at = outbox_wr;
                instr_at = instr; opnd_at = operand;
            end else if (inbox_rd !== 1'b0 || outbox_wr !== 1'b0) begin
                stray++;
            end
            if (exp_halt && i == lat) break;
        end
        checks++;
        if (stray != 0) begin
            errors++;
            $display("FAIL %s stray_strobe: %0d strobes outside commit, want 0", tag, stray);
        end
        if (exp_halt) begin
            checks++;
            if (c >= 0 || halted !== 1'b1 || pc !== seq_pc) begin
                errors++;
                $display("FAIL %s halt: exec_idx=%0d halted=%b pc=%h, want -1/1/%h", tag, c, halted, pc, seq_pc);
            end
            pc_m = seq_pc;
        end else begin
            checks++;
            if (c != exp_c) begin
                errors++;
                $display("FAIL %s commit_cycle: got %0d want %0d", tag, c, exp_c);
            end
            checks++;
            if (ird_at !== (op == OP_INBOX) || owr_at !== (op == OP_OUTBOX) || instr_at !== op) begin
                errors++;
                $display("FAIL %s commit_strobes: rd=%b wr=%b instr=%h, want %b/%b/%h", tag, ird_at, owr_at, instr_at, op == OP_INBOX, op == OP_OUTBOX, op);
            end
            if (has) begin
                checks++;
                if (opnd_at !== arg) begin
                    errors++;
                    $display("FAIL %s operand: got %h want %h", tag, opnd_at, arg);
                end
            end
            take = (op == OP_JUMP) || (op == OP_JUMPZ && z_at) || (op == OP_JUMPN && n_at);
            exp_pc = take ? arg : seq_pc;
            if (op == OP_INBOX) inbox_cnt--;
            @(negedge clk);
            outbox_full = 1'b0;
            #1;
            checks++;
            if (pc !== exp_pc || exec_en !== 1'b0) begin
                errors++;
                $display("FAIL %s next_pc: pc=%h exec_en=%b, want %h/0", tag, pc, exec_en, exp_pc);
            end
            pc_m = exp_pc;
        end
    endtask

    task automatic test_reset();
        clear_rom();
        rom[0] = 8'h20; rom[1] = 8'h33;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (pc !== 8'h00 || pm_addr !== 8'h00 || exec_en !== 1'b0 || inbox_rd !== 1'b0 ||
            outbox_wr !== 1'b0 || halted !== 1'b0 || instr !== 4'h0 || operand !== 8'h00) begin
            errors++;
            $display("FAIL reset_state: pc=%h addr=%h en=%b rd=%b wr=%b h=%b instr=%h opnd=%h, want all 0",
                     pc, pm_addr, exec_en, inbox_rd, outbox_wr, halted, instr, operand);
        end
        do_reset();
        // Advance F_OP -> L_OP -> F_ARG -> L_ARG, then reset inside L_ARG.
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (pc !== 8'h01 || instr !== OP_COPYFROM) begin
            errors++;
            $display("FAIL reset_pre_l_arg: pc=%h instr=%h, want 01/2", pc, instr);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (pc !== 8'h00 || instr !== 4'h0 || operand !== 8'h00 || exec_en !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_instr: pc=%h instr=%h opnd=%h en=%b, want 0", pc, instr, operand, exec_en);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (pm_addr !== 8'h00 || pc !== 8'h00 || exec_en !== 1'b0 || inbox_rd !== 1'b0 || outbox_wr !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: addr=%h pc=%h en=%b, want 0", pm_addr, pc, exec_en);
        end
        do_reset();
        inbox_cnt = 0;
        run_instr(0, -1, -1, "reset_copyfrom");
    endtask

    task automatic test_io();
        clear_rom();
        rom[0] = 8'h00; rom[1] = 8'h10; rom[2] = 8'h00; rom[3] = 8'h10; rom[4] = 8'h00;
        inbox_cnt = 2;
        do_reset();
        run_instr(0, -1, -1, "io_in1");
        run_instr(0, -1, -1, "io_out1");
        run_instr(0, -1, -1, "io_in2");
        run_instr(0, -1, -1, "io_out2");
        run_instr(0, -1, -1, "io_in_empty");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if (halted !== 1'b1 || exec_en !== 1'b0 || inbox_rd !== 1'b0 || instr !== OP_INBOX || pc !== 8'h05) begin
                errors++;
                $display("FAIL halt_hold: h=%b en=%b rd=%b instr=%h pc=%h", halted, exec_en, inbox_rd, instr, pc);
            end
        end
    endtask

    task automatic test_branch();
        inbox_cnt = 0;
        clear_rom();
        rom[0] = 8'hA0; rom[1] = 8'h10;
        do_reset();
        run_instr(0, 1, -1, "jumpz_taken");
        checks++;
        if (pc !== 8'h10) begin
            errors++;
            $display("FAIL jumpz_taken_pc: got %h want 10", pc);
        end
        do_reset();
        run_instr(0, 0, -1, "jumpz_not_taken");
        checks++;
        if (pc !== 8'h02) begin
            errors++;
            $display("FAIL jumpz_not_taken_pc: got %h want 02", pc);
        end
        rom[0] = 8'hB0; rom[1] = 8'h77;
        for (int k = 0; k < 4; k++) begin
            do_reset();
            run_instr(0, -1, k & 1, "jumpn");
        end
    endtask

    task automatic test_outbox_wait();
        inbox_cnt = 0;
        clear_rom();
        rom[0] = 8'h10; rom[1] = 8'h10; rom[2] = 8'h10;
        do_reset();
        run_instr(4, -1, -1, "outbox_full4");
        run_instr(int'($urandom_range(1, 3)), -1, -1, "outbox_full_rand");
        run_instr(0, -1, -1, "outbox_free");
    endtask

    task automatic test_wrap();
        inbox_cnt = 0;
        clear_rom();
        rom[0] = 8'h80; rom[1] = 8'hFE;
        rom[8'hFE] = 8'h80; rom[8'hFF] = 8'h42;
        rom[8'h42] = 8'hF0; rom[8'h43] = 8'h5A;
        do_reset();
        run_instr(0, -1, -1, "jump_to_fe");
        run_instr(0, -1, -1, "jump_wrap");
        checks++;
        if (pc !== 8'h42) begin
            errors++;
            $display("FAIL wrap_target: got %h want 42", pc);
        end
        run_instr(0, -1, -1, "halt_op");
    endtask

    task automatic test_random();
        logic [3:0] ops [11];
        logic [3:0] op;
        ops = '{OP_INBOX, OP_OUTBOX, OP_COPYFROM, OP_COPYTO, OP_ADD, OP_SUB,
                OP_BUMPP, OP_BUMPN, OP_JUMP, OP_JUMPZ, OP_JUMPN};
        for (int a = 0; a < 256; a++)
            rom[a] = {ops[$urandom_range(0, 10)], 4'($urandom)};
        inbox_cnt = 1000000;
        do_reset();
        for (int n = 0; n < 60; n++) begin
            op = rom[pc_m][7:4];
            run_instr((op == OP_OUTBOX) ? int'($urandom_range(0, 3)) : 0, -1, -1, "random");
        end
    endtask

`ifdef INSTR_SEQUENCER_STEP_EN
    task automatic test_step();
        int cnt;
        clear_rom();
        run = 1'b0;
        do_reset();
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #1;
            if (exec_en === 1'b1) cnt++;
        end
        checks++;
        if (cnt != 0 || pc !== 8'h00) begin
            errors++;
            $display("FAIL step_idle: exec=%0d pc=%h, want 0/00", cnt, pc);
        end
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            #1;
            if (exec_en === 1'b1) cnt++;
        end
        checks++;
        if (cnt != 1 || pc !== 8'h01) begin
            errors++;
            $display("FAIL step_one: exec=%0d pc=%h, want 1/01", cnt, pc);
        end
        run = 1'b1;
    endtask
`endif

    initial begin
        clear_rom();
        pc_m = 8'h00;
        inbox_cnt = 0;
        repeat (2) @(negedge clk);
        test_reset();
        test_io();
        test_branch();
        test_outbox_wait();
        test_wrap();
        test_random();
`ifdef INSTR_SEQUENCER_STEP_EN
        test_step();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
